// File: rtl/skintone_stream_ctrl_if.sv
// rtl/skintone_stream_ctrl_if.sv - pixel in, datapath and score out streams of skintone_stream_ctrl
interface skintone_stream_ctrl_if;
  logic [23:0] s_pixel;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] dp_pixel;
  logic        dp_pixel_valid;
  logic [7:0]  dp_result;
  logic        dp_result_valid;
  logic [7:0]  m_score;
  logic        m_valid;
  logic        m_ready;

  modport master (
    input  s_pixel, s_valid, dp_result, dp_result_valid, m_ready,
    output s_ready, dp_pixel, dp_pixel_valid, m_score, m_valid
  );

  modport slave (
    output s_pixel, s_valid, dp_result, dp_result_valid, m_ready,
    input  s_ready, dp_pixel, dp_pixel_valid, m_score, m_valid
  );
endinterface

// File: rtl/skintone_stream_ctrl.sv
// rtl/skintone_stream_ctrl.sv - frame sequencer and credit flow control around skintone_datapath
// Define SKINTONE_CTRL_STATS_EN to add the hit_count/hit_valid statistics outputs.
module skintone_stream_ctrl #(
  parameter int DP_LATENCY = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_W      = 20
`ifdef SKINTONE_CTRL_STATS_EN
  ,
  parameter logic [7:0] SCORE_THRESH = 8'd1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
`ifdef SKINTONE_CTRL_STATS_EN
  output logic [LEN_W-1:0] hit_count,
  output logic             hit_valid,
`endif
  skintone_stream_ctrl_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(DP_LATENCY + 1);
  localparam int IW = $clog2(DP_LATENCY + 2);
  localparam int SW = AW + 2;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(DP_LATENCY - 1);
  localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_FLUSH, ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             done_q, done_d;
  logic [7:0]       mem [FIFO_DEPTH];

  logic [AW:0] fifo_cnt;
  logic        fifo_empty, fifo_full, credit_ok;
  logic        issue, res_wr, out_fire, last_out, start_ok;

  // Every issued pixel owns a FIFO slot until its score leaves, so a result never overflows.
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_CNT);
  assign credit_ok  = (SW'(fifo_cnt) + SW'(inflight_q)) < SW'(FIFO_DEPTH);

  assign bus.s_ready        = !rst && (state_q == ST_RUN) && (issued_q < len_q) && credit_ok;
  assign issue              = bus.s_valid && bus.s_ready;
  assign bus.dp_pixel       = bus.s_pixel;
  assign bus.dp_pixel_valid = issue;

  assign res_wr      = bus.dp_result_valid && (state_q != ST_FLUSH);
  assign bus.m_valid = !fifo_empty && (state_q != ST_FLUSH);
  assign bus.m_score = bus.m_valid ? mem[rd_ptr_q[AW-1:0]] : 8'd0;
  assign out_fire    = bus.m_valid && bus.m_ready;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign last_out = out_fire && (state_q == ST_DRAIN) && (out_cnt_q == len_q - LEN_W'(1));
  assign done     = done_q || last_out;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    len_d       = len_q;
    issued_d    = issued_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = inflight_q;
    done_d      = 1'b0;
    wr_ptr_d    = res_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d    = out_fire ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    if (issue)    issued_d  = issued_q + LEN_W'(1);
    if (out_fire) out_cnt_d = out_cnt_q + LEN_W'(1);

    case ({issue, res_wr})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      ST_FLUSH: begin
        // The datapath has no reset; wait out one full pipeline of possibly stale results.
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_IDLE;
        else                           flush_cnt_d = flush_cnt_q + FW'(1);
      end
      ST_IDLE: begin
        if (start) begin
          len_d     = frame_len;
          issued_d  = '0;
          out_cnt_d = '0;
          if (frame_len == '0) done_d  = 1'b1;
          else                 state_d = ST_RUN;
        end
      end
      ST_RUN:   if (issued_q == len_q) state_d = ST_DRAIN;
      ST_DRAIN: if (last_out)          state_d = ST_IDLE;
      default:  state_d = ST_FLUSH;
    endcase
  end

`ifdef SKINTONE_CTRL_STATS_EN
  logic [LEN_W-1:0] hit_count_q, hit_count_d;
  logic             hit_valid_q, hit_valid_d;

  always_comb begin
    hit_count_d = hit_count_q;
    hit_valid_d = hit_valid_q;
    if (out_fire && (bus.m_score >= SCORE_THRESH)) hit_count_d = hit_count_q + LEN_W'(1);
    if (done) hit_valid_d = 1'b1;
    if (start_ok) begin
      hit_count_d = '0;
      hit_valid_d = 1'b0;
    end
  end

  assign hit_count = hit_count_q;
  assign hit_valid = hit_valid_q || done;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      done_q      <= 1'b0;
`ifdef SKINTONE_CTRL_STATS_EN
      hit_count_q <= '0;
      hit_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      done_q      <= done_d;
`ifdef SKINTONE_CTRL_STATS_EN
      hit_count_q <= hit_count_d;
      hit_valid_q <= hit_valid_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (res_wr) mem[wr_ptr_q[AW-1:0]] <= bus.dp_result;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(res_wr && fifo_full));
  a_inflight_max: assert property (@(posedge clk) disable iff (rst) inflight_q <= IW'(DP_LATENCY + 1));

endmodule

// File: tb/tb_skintone_stream_ctrl.sv
// tb/tb_skintone_stream_ctrl.sv - randomized self-checking bench for skintone_stream_ctrl
module tb_skintone_stream_ctrl;
  localparam int DPL   = 16;
  localparam int DEPTH = 32;
  localparam int LW    = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          busy;
  logic          done;
`ifdef SKINTONE_CTRL_STATS_EN
  logic [LW-1:0] hit_count;
  logic          hit_valid;
`endif

  skintone_stream_ctrl_if bus ();

  skintone_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .busy      (busy),
    .done      (done),
`ifdef SKINTONE_CTRL_STATS_EN
    .hit_count (hit_count),
    .hit_valid (hit_valid),
`endif
    .bus       (bus)
  );

  function automatic logic [7:0] skin_score(input logic [23:0] p);
    logic [7:0] y, cb, cr;
    y  = p[23:16];
    cb = p[15:8];
    cr = p[7:0];
    return (cb >= 8'd77 && cb <= 8'd127 && cr >= 8'd133 && cr <= 8'd173) ? y : 8'd0;
  endfunction

  function automatic logic [23:0] rand_pixel();
    logic [7:0] y, cb, cr;
    y  = 8'($urandom_range(255));
    cb = 8'($urandom_range(140, 60));
    cr = 8'($urandom_range(190, 120));
    return {y, cb, cr};
  endfunction

  // Datapath stand-in: fixed 16-cycle pipeline with no reset, like the real one.
  logic       pv [DPL];
  logic [7:0] ps [DPL];
  always @(posedge clk) begin
    pv[0] <= bus.dp_pixel_valid;
    ps[0] <= skin_score(bus.dp_pixel);
    for (int i = 1; i < DPL; i++) begin
      pv[i] <= pv[i-1];
      ps[i] <= ps[i-1];
    end
  end
  assign bus.dp_result_valid = pv[DPL-1];
  assign bus.dp_result       = ps[DPL-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_issued, n_out, n_done, done_at_out, first_issue, first_mv, exp_hits;
  int valid_pct = 100;
  int ready_pct = 100;
  logic          pend_start = 1'b0;
  logic [LW-1:0] pend_len   = '0;
  logic          rst_req    = 1'b1;
  logic [7:0]    exp_q [$];
  logic [23:0]   dir_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic       in_fire, out_fire;
    logic [7:0] exp_s;
    @(posedge clk);
    #1;
    rst        = rst_req;
    start      = pend_start;
    frame_len  = pend_len;
    pend_start = 1'b0;
    if (dir_q.size() > 0) begin
      bus.s_valid = 1'b1;
      bus.s_pixel = dir_q[0];
    end else begin
      bus.s_valid = ($urandom_range(99) < valid_pct);
      bus.s_pixel = rand_pixel();
    end
    bus.m_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    cyc++;
    if (!rst) begin
      in_fire  = bus.s_valid && bus.s_ready;
      out_fire = bus.m_valid && bus.m_ready;
      check("dp_valid", bus.dp_pixel_valid, in_fire);
      if (in_fire) begin
        check("credit", (n_issued - n_out) < DEPTH, 1);
        check("dp_pixel", bus.dp_pixel, bus.s_pixel);
        exp_q.push_back(skin_score(bus.s_pixel));
        n_issued++;
        if (first_issue < 0) first_issue = cyc;
        if (dir_q.size() > 0) void'(dir_q.pop_front());
      end
      if (bus.m_valid && first_mv < 0) first_mv = cyc;
      if (out_fire) begin
        check("exp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_s = exp_q.pop_front();
          check("score", bus.m_score, exp_s);
          if (exp_s >= 8'd1) exp_hits++;
        end
        n_out++;
      end
      if (done) begin
        n_done++;
        done_at_out = n_out;
      end
    end
  endtask

  task automatic begin_frame(input int len);
    n_issued    = 0;
    n_out       = 0;
    n_done      = 0;
    done_at_out = -1;
    first_issue = -1;
    first_mv    = -1;
    exp_hits    = 0;
    pend_start  = 1'b1;
    pend_len    = LW'(len);
  endtask

  task automatic wait_done(input int len, input int budget);
    int b;
    b = 0;
    while (n_done == 0 && b < budget) begin
      tick();
      b++;
    end
    check("done_seen", n_done > 0, 1);
    repeat (4) tick();
    check("done_count", n_done, 1);
    check("done_on_last", done_at_out, len);
    check("scores_out", n_out, len);
    check("queue_empty", exp_q.size(), 0);
    check("busy_after", busy, 0);
`ifdef SKINTONE_CTRL_STATS_EN
    check("hit_valid", hit_valid, 1);
    check("hit_count", hit_count, exp_hits);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int b, mv_seen;
    bus.s_valid = 1'b0;
    bus.s_pixel = '0;
    bus.m_ready = 1'b0;
    start       = 1'b0;
    frame_len   = '0;
    rst         = 1'b1;

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_dp_valid", bus.dp_pixel_valid, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_score", bus.m_score, 0);
`ifdef SKINTONE_CTRL_STATS_EN
    check("rst_hit_valid", hit_valid, 0);
`endif

    // Start during FLUSH must be ignored.
    rst_req = 1'b0;
    begin_frame(5);
    repeat (4) tick();
    check("flush_start_busy", busy, 0);
    check("flush_start_issue", n_issued, 0);
    repeat (DPL) tick();

    // Basic frame and first-result latency.
    valid_pct = 100;
    ready_pct = 100;
    begin_frame(4);
    wait_done(4, 200);
    check("latency", first_mv - first_issue, DPL + 1);

    // Zero-length frame.
    begin_frame(0);
    tick();
    check("zero_len_start_cycle_done", done, 0);
    tick();
    check("zero_len_done", done, 1);
    check("zero_len_s_ready", bus.s_ready, 0);
    check("zero_len_busy", busy, 0);
    tick();
    check("zero_len_done_pulse", done, 0);

    // Back-pressure: credits run out after exactly FIFO_DEPTH issues.
    ready_pct = 0;
    begin_frame(100);
    repeat (80) tick();
    check("stall_issues", n_issued, DEPTH);
    check("stall_s_ready", bus.s_ready, 0);
    check("stall_m_valid", bus.m_valid, 1);
    ready_pct = 100;
    wait_done(100, 2000);

    // Directed scores including range boundaries.
    ready_pct = 60;
    dir_q.push_back({8'd77, 8'd20, 8'd150});
    dir_q.push_back({8'd0, 8'd100, 8'd150});
    dir_q.push_back({8'd5, 8'd77, 8'd133});
    dir_q.push_back({8'd200, 8'd127, 8'd173});
    begin_frame(4);
    wait_done(4, 300);
`ifdef SKINTONE_CTRL_STATS_EN
    check("hit_count_vec", hit_count, 2);
`endif

    // Long random frame.
    valid_pct = 50;
    ready_pct = 50;
    begin_frame(1000);
    wait_done(1000, 20000);

    // Reset mid-frame after 10 issues.
    valid_pct = 100;
    ready_pct = 100;
    begin_frame(50);
    b = 0;
    while (n_issued < 10 && b < 200) begin
      tick();
      b++;
    end
    check("mid_reset_issued", n_issued, 10);
    rst_req = 1'b1;
    repeat (2) tick();
    rst_req = 1'b0;
    exp_q.delete();
    mv_seen = 0;
    repeat (DPL + 1) begin
      tick();
      if (bus.m_valid) mv_seen++;
    end
    check("flush_m_valid", mv_seen, 0);
    repeat (3) tick();
    begin_frame(3);
    wait_done(3, 300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
